reorder_buffer: RTL and testbench
=================================

# reorder_buffer

In-order retirement buffer that sits between dispatch (decode/rename) and the register-rename commit port. It allocates one entry per dispatched instruction and records completion from the execution units. It retires entries strictly in program order, one per cycle. On retirement it drives the commit/free-list signals (commit_P_rd_new, commit_P_rd_old, commit_A_rd, commit_wb_en) and the recovery pulse that the rename stage consumes.

## Interface
- DEPTH, 16, number of entries; power of two
- TAG_W, 4, log2(DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dis_valid  in  1  dispatch request
- dis_ready  out  1  entry available; transfer when dis_valid && dis_ready
- dis_pc  in  16  instruction PC
- dis_P_rd_new  in  7  newly allocated physical rd
- dis_P_rd_old  in  7  previous mapping of rd
- dis_A_rd  in  6  architectural rd ({fp, idx})
- dis_use_rd  in  1  instruction writes rd
- dis_tag  out  TAG_W  index of the entry allocated on this transfer (= tail)
- wb_valid  in  1  completion report
- wb_tag  in  TAG_W  entry completing
- wb_mispredict  in  1  completing instruction was a mispredicted control transfer
- commit_valid  out  1  one entry retired (registered pulse)
- commit_pc  out  16  PC of retired entry
- commit_P_rd_new  out  7  retired entry's P_rd_new
- commit_P_rd_old  out  7  retired entry's P_rd_old, to be freed
- commit_A_rd  out  6  retired entry's A_rd
- commit_wb_en  out  1  commit_valid && stored use_rd && A_rd != 0
- recovery  out  1  registered pulse; flush all younger state
- rob_empty  out  1  no valid entries

## Operation
- Storage: per entry pc, P_rd_new, P_rd_old, A_rd, use_rd, done, mispredict.
- Pointers head, tail: TAG_W+1 bits, wrap bit in MSB. Empty when head==tail. Full when index bits are equal and wrap bits differ.
- dis_ready = !full && !recovery. There is no same-cycle bypass from commit: a full buffer refuses dispatch even in a cycle that retires.
- Dispatch transfer:
  - write entry[tail] with done=0, mispredict=0
  - tail += 1
  - dis_tag is combinational from tail
- Writeback with wb_valid:
  - set done[wb_tag]=1 and mispredict[wb_tag]=wb_mispredict
  - a wb_tag pointing at an invalid slot is ignored
  - wb_valid is ignored in any cycle where recovery=1
- Retire, when !empty && done[head]:
  - head += 1
  - register the commit_* outputs from entry[head]; commit_valid=1 for exactly one cycle
  - if that entry's mispredict=1: recovery=1 in the same output cycle, and tail <= head+1, which empties the buffer
- Otherwise commit_valid, commit_wb_en and recovery are 0. The other commit_* outputs hold their last value.
- Simultaneous dispatch and retire: both pointers advance and occupancy is unchanged.
- Simultaneous dispatch and flush decision on the same edge: the flush wins, and the dispatched entry is discarded (tail is overwritten). The rename stage also discards it because recovery follows.
- Wrap-around: index bits roll DEPTH-1 → 0 and the wrap bit toggles. Capacity is DEPTH entries.
- Reset mid-operation: all entries invalidated on the next edge; in-flight wb and dispatch are ignored.

## Timing
- Reset values: head=tail=0; commit_valid=0, commit_wb_en=0, recovery=0, commit_pc=0, commit_P_rd_new=0, commit_P_rd_old=0, commit_A_rd=0. This gives rob_empty=1, dis_ready=1 and dis_tag=0.
- Dispatch at edge k: the entry is valid after k; the earliest legal wb for it is at edge k+1.
- Writeback sampled at edge k: if the entry is at head, it retires at edge k+1 and commit_* is visible in the cycle after k+1. This is 2 edges from wb to commit output.
- Throughput: one retire per cycle when consecutive head entries are done.
- recovery is high for one cycle coincident with commit_valid of the mispredicted entry. dis_ready=0 during that cycle.

## Test plan
- Reset, then dispatch 3 entries: pc 0x10/0x14/0x18, A_rd 5/6/0, P_rd_new 64/65/66, use_rd=1. Expect dis_tag 0,1,2.
  - wb tags 2,0,1 in consecutive cycles.
  - Commits appear in order 0x10, 0x14, 0x18: commit_P_rd_old passes through; commit_wb_en = 1, 1, 0 (A_rd=0).
- Fill 16 entries without wb: dis_ready=0 and rob_empty=0. wb tag 0 → one commit; dis_ready returns to 1 only in the following cycle.
- Dispatch 20 with steady wb/retire, occupancy ≤ 4. Expect the tag sequence to wrap 15 → 0, all 20 commit in order, and rob_empty=1 at the end.
- Dispatch 4 entries; wb tag 1 with mispredict=1, plus tags 0, 2, 3.
  - Commit tag 0, then tag 1 with recovery=1 in the same cycle.
  - Tags 2 and 3 never commit; rob_empty=1 next cycle.
  - A dis_valid held during the recovery cycle sees dis_ready=0.
- Store (use_rd=0, A_rd=0x02) commits with commit_wb_en=0. wb_valid to an unallocated tag causes no commit.
- Assert rst while 5 entries are pending and commit_valid=1. Next cycle all outputs are at reset values and rob_empty=1; a subsequent dispatch gets dis_tag=0.

Source files
------------

// File: rtl/reorder_buffer.sv
// In-order retirement buffer between dispatch and the rename commit port.
// Entries are allocated at tail, marked done by writeback, and retired from
// head one per cycle. A retiring mispredicted entry flushes every younger
// entry and raises a one-cycle recovery pulse alongside its commit.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dis_valid,
  output logic             dis_ready,
  input  logic [15:0]      dis_pc,
  input  logic [6:0]       dis_P_rd_new,
  input  logic [6:0]       dis_P_rd_old,
  input  logic [5:0]       dis_A_rd,
  input  logic             dis_use_rd,
  output logic [TAG_W-1:0] dis_tag,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic             wb_mispredict,
  output logic             commit_valid,
  output logic [15:0]      commit_pc,
  output logic [6:0]       commit_P_rd_new,
  output logic [6:0]       commit_P_rd_old,
  output logic [5:0]       commit_A_rd,
  output logic             commit_wb_en,
  output logic             recovery,
  output logic             rob_empty
);

  localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

  // Pointers carry a wrap bit in the MSB so full and empty are distinguishable.
  logic [TAG_W:0]   head;
  logic [TAG_W:0]   tail;
  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;

  logic [15:0]      pc_mem     [DEPTH];
  logic [6:0]       prd_new_mem[DEPTH];
  logic [6:0]       prd_old_mem[DEPTH];
  logic [5:0]       ard_mem    [DEPTH];
  logic [DEPTH-1:0] use_mem;
  logic [DEPTH-1:0] done_mem;
  logic [DEPTH-1:0] misp_mem;

  logic empty;
  logic full;
  logic dis_fire;
  logic wb_fire;
  logic retire;
  logic flush;

  // A tag is live when its distance from head is below the occupancy.
  function automatic logic in_window(input logic [TAG_W-1:0] tag,
                                     input logic [TAG_W:0]   hd,
                                     input logic [TAG_W:0]   tl);
    logic [TAG_W:0] ofs;
    logic [TAG_W:0] cnt;
    ofs = {1'b0, tag - hd[TAG_W-1:0]};
    cnt = tl - hd;
    return ofs < cnt;
  endfunction

  assign head_idx  = head[TAG_W-1:0];
  assign tail_idx  = tail[TAG_W-1:0];
  assign empty     = (head == tail);
  assign full      = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
  assign dis_ready = !full && !recovery;
  assign dis_tag   = tail_idx;
  assign rob_empty = empty;
  assign dis_fire  = dis_valid && dis_ready;
  assign wb_fire   = wb_valid && !recovery && in_window(wb_tag, head, tail);
  assign retire    = !empty && done_mem[head_idx];
  assign flush     = retire && misp_mem[head_idx];

  // Payload capture on dispatch; slots are only read once known to be live.
  always_ff @(posedge clk) begin
    if (dis_fire) begin
      pc_mem[tail_idx]      <= dis_pc;
      prd_new_mem[tail_idx] <= dis_P_rd_new;
      prd_old_mem[tail_idx] <= dis_P_rd_old;
      ard_mem[tail_idx]     <= dis_A_rd;
      use_mem[tail_idx]     <= dis_use_rd;
    end
  end

  // Completion status: cleared at allocation, set by writeback to live slots.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (dis_fire) begin
        done_mem[tail_idx] <= 1'b0;
        misp_mem[tail_idx] <= 1'b0;
      end
      if (wb_fire) begin
        done_mem[wb_tag] <= 1'b1;
        misp_mem[wb_tag] <= wb_mispredict;
      end
    end
  end

  // Pointer update; a flush collapses tail onto the new head and drops dispatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (retire) begin
        head <= head + PTR_ONE;
      end
      if (flush) begin
        tail <= head + PTR_ONE;
      end else if (dis_fire) begin
        tail <= tail + PTR_ONE;
      end
    end
  end

  // Registered commit stage: pulses for one cycle, payload holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_valid    <= 1'b0;
      commit_wb_en    <= 1'b0;
      recovery        <= 1'b0;
      commit_pc       <= '0;
      commit_P_rd_new <= '0;
      commit_P_rd_old <= '0;
      commit_A_rd     <= '0;
    end else begin
      commit_valid <= retire;
      recovery     <= flush;
      commit_wb_en <= retire && use_mem[head_idx] && (ard_mem[head_idx] != '0);
      if (retire) begin
        commit_pc       <= pc_mem[head_idx];
        commit_P_rd_new <= prd_new_mem[head_idx];
        commit_P_rd_old <= prd_old_mem[head_idx];
        commit_A_rd     <= ard_mem[head_idx];
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: a queue-based reference model predicts commits,
// which a separate monitor checks whenever the buffer presents a commit.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        dis_valid;
  logic        dis_ready;
  logic [15:0] dis_pc;
  logic [6:0]  dis_P_rd_new;
  logic [6:0]  dis_P_rd_old;
  logic [5:0]  dis_A_rd;
  logic        dis_use_rd;
  logic [3:0]  dis_tag;
  logic        wb_valid;
  logic [3:0]  wb_tag;
  logic        wb_mispredict;
  logic        commit_valid;
  logic [15:0] commit_pc;
  logic [6:0]  commit_P_rd_new;
  logic [6:0]  commit_P_rd_old;
  logic [5:0]  commit_A_rd;
  logic        commit_wb_en;
  logic        recovery;
  logic        rob_empty;

  reorder_buffer #(.DEPTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .dis_valid(dis_valid), .dis_ready(dis_ready), .dis_pc(dis_pc),
    .dis_P_rd_new(dis_P_rd_new), .dis_P_rd_old(dis_P_rd_old),
    .dis_A_rd(dis_A_rd), .dis_use_rd(dis_use_rd), .dis_tag(dis_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_mispredict(wb_mispredict),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_P_rd_new(commit_P_rd_new), .commit_P_rd_old(commit_P_rd_old),
    .commit_A_rd(commit_A_rd), .commit_wb_en(commit_wb_en),
    .recovery(recovery), .rob_empty(rob_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic [15:0] pc;
    logic [6:0]  pn;
    logic [6:0]  po;
    logic [5:0]  ar;
    bit          use_rd;
    bit          done;
    bit          misp;
  } ent_t;

  typedef struct {
    logic [15:0] pc;
    logic [6:0]  pn;
    logic [6:0]  po;
    logic [5:0]  ar;
    bit          wben;
    bit          recov;
  } cmt_t;

  ent_t       rob_q[$];
  cmt_t       exp_q[$];
  logic [3:0] m_next_tag = '0;
  bit         m_recov = 1'b0;
  bit         started = 1'b0;
  bit         mon_en = 1'b0;
  int         n_vec = 0;
  int         n_bad = 0;
  cmt_t       mon_c;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: advance one clock edge using the inputs currently driven.
  task automatic model_step();
    ent_t h;
    ent_t e;
    cmt_t c;
    bit   ret;
    bit   fl;
    bit   rdy;
    if (rst) begin
      rob_q.delete();
      m_next_tag = '0;
      m_recov    = 1'b0;
      return;
    end
    rdy = (rob_q.size() < 16) && !m_recov;
    ret = (rob_q.size() > 0) && rob_q[0].done;
    fl  = 1'b0;
    if (ret) h = rob_q[0];
    if (wb_valid && !m_recov) begin
      foreach (rob_q[i]) begin
        if (rob_q[i].tag == wb_tag) begin
          rob_q[i].done = 1'b1;
          rob_q[i].misp = wb_mispredict;
        end
      end
    end
    if (ret) begin
      c.pc    = h.pc;
      c.pn    = h.pn;
      c.po    = h.po;
      c.ar    = h.ar;
      c.wben  = h.use_rd && (h.ar != 6'd0);
      c.recov = h.misp;
      exp_q.push_back(c);
      void'(rob_q.pop_front());
      if (h.misp) begin
        fl = 1'b1;
        rob_q.delete();
        m_next_tag = h.tag + 4'd1;
      end
    end
    if (dis_valid && rdy && !fl) begin
      e.tag    = m_next_tag;
      e.pc     = dis_pc;
      e.pn     = dis_P_rd_new;
      e.po     = dis_P_rd_old;
      e.ar     = dis_A_rd;
      e.use_rd = dis_use_rd;
      e.done   = 1'b0;
      e.misp   = 1'b0;
      rob_q.push_back(e);
      m_next_tag = m_next_tag + 4'd1;
    end
    m_recov = fl;
  endtask

  // One clock: check current-cycle status, advance the model, move to next negedge.
  task automatic cyc();
    #1;
    if (started) begin
      check("dis_ready", 32'(dis_ready), 32'((rob_q.size() < 16) && !m_recov));
      check("dis_tag", 32'(dis_tag), 32'(m_next_tag));
      check("rob_empty", 32'(rob_empty), 32'(rob_q.size() == 0));
    end
    model_step();
    @(negedge clk);
  endtask

  task automatic set_idle();
    dis_valid     = 1'b0;
    wb_valid      = 1'b0;
    wb_mispredict = 1'b0;
  endtask

  task automatic set_dis(input logic [15:0] pc, input logic [6:0] pn, input logic [6:0] po,
                         input logic [5:0] ar, input logic u);
    dis_valid    = 1'b1;
    dis_pc       = pc;
    dis_P_rd_new = pn;
    dis_P_rd_old = po;
    dis_A_rd     = ar;
    dis_use_rd   = u;
  endtask

  task automatic set_wb(input logic [3:0] t, input logic m);
    wb_valid      = 1'b1;
    wb_tag        = t;
    wb_mispredict = m;
  endtask

  task automatic rand_dis();
    set_dis(16'($urandom), 7'($urandom), 7'($urandom), 6'($urandom), 1'($urandom));
  endtask

  function automatic int first_pending();
    foreach (rob_q[i]) if (!rob_q[i].done) return i;
    return -1;
  endfunction

  task automatic check_reset_outs();
    check("rst_commit_valid", 32'(commit_valid), 0);
    check("rst_commit_wb_en", 32'(commit_wb_en), 0);
    check("rst_recovery", 32'(recovery), 0);
    check("rst_commit_pc", 32'(commit_pc), 0);
    check("rst_commit_prd_new", 32'(commit_P_rd_new), 0);
    check("rst_commit_prd_old", 32'(commit_P_rd_old), 0);
    check("rst_commit_ard", 32'(commit_A_rd), 0);
    check("rst_rob_empty", 32'(rob_empty), 1);
    check("rst_dis_ready", 32'(dis_ready), 1);
    check("rst_dis_tag", 32'(dis_tag), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    cyc();
    rst     = 1'b0;
    started = 1'b1;
    mon_en  = 1'b1;
    check_reset_outs();
  endtask

  // Complete every outstanding entry oldest-first and let the buffer empty.
  task automatic drain();
    int k;
    for (int i = 0; i < 80; i++) begin
      if (rob_q.size() == 0 && exp_q.size() == 0) break;
      set_idle();
      k = first_pending();
      if (k >= 0 && !m_recov) set_wb(rob_q[k].tag, 1'b0);
      cyc();
    end
    set_idle();
    cyc();
    #2;
    check("drain_outstanding", 32'(exp_q.size()), 0);
    check("drain_empty", 32'(rob_empty), 1);
  endtask

  // Commit monitor: every presented commit must match the oldest prediction.
  always @(negedge clk) begin
    if (mon_en) begin
      if (commit_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_commit", 32'(commit_pc), 32'hFFFF_FFFF);
        end else begin
          mon_c = exp_q.pop_front();
          check("commit_pc", 32'(commit_pc), 32'(mon_c.pc));
          check("commit_prd_new", 32'(commit_P_rd_new), 32'(mon_c.pn));
          check("commit_prd_old", 32'(commit_P_rd_old), 32'(mon_c.po));
          check("commit_ard", 32'(commit_A_rd), 32'(mon_c.ar));
          check("commit_wb_en", 32'(commit_wb_en), 32'(mon_c.wben));
          check("commit_recovery", 32'(recovery), 32'(mon_c.recov));
        end
      end else begin
        check("idle_pulses", 32'({commit_valid, recovery, commit_wb_en}), 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int sent;
    rst = 1'b1;
    set_idle();
    set_dis(16'h0, 7'h0, 7'h0, 6'h0, 1'b0);
    dis_valid = 1'b0;
    wb_tag    = '0;
    @(negedge clk);
    do_reset();

    // In-order commit of out-of-order completions.
    set_dis(16'h10, 7'd64, 7'd20, 6'd5, 1'b1); cyc();
    set_dis(16'h14, 7'd65, 7'd21, 6'd6, 1'b1); cyc();
    set_dis(16'h18, 7'd66, 7'd22, 6'd0, 1'b1); cyc();
    set_idle(); set_wb(4'd2, 1'b0); cyc();
    set_wb(4'd0, 1'b0); cyc();
    set_wb(4'd1, 1'b0); cyc();
    drain();

    // Fill to capacity, then free one slot with dispatch held.
    do_reset();
    for (int i = 0; i < 16; i++) begin rand_dis(); cyc(); end
    rand_dis(); cyc();
    cyc();
    set_wb(4'd0, 1'b0); cyc();
    wb_valid = 1'b0; cyc();
    cyc();
    set_idle();
    drain();

    // Steady streaming across the tag wrap.
    do_reset();
    sent = 0;
    for (int i = 0; i < 80 && sent < 20; i++) begin
      set_idle();
      if (rob_q.size() < 4) begin rand_dis(); sent++; end
      k = first_pending();
      if (k >= 0) set_wb(rob_q[k].tag, 1'b0);
      cyc();
    end
    drain();

    // Mispredict flush with dispatch held through the recovery cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin rand_dis(); cyc(); end
    set_idle(); set_wb(4'd1, 1'b1); cyc();
    set_wb(4'd0, 1'b0); cyc();
    set_wb(4'd2, 1'b0); cyc();
    set_wb(4'd3, 1'b0); rand_dis(); cyc();
    set_wb(4'd2, 1'b0); rand_dis(); cyc();
    wb_valid = 1'b0; rand_dis(); cyc();
    set_idle();
    drain();

    // Store without rd write, and writeback to an unallocated tag.
    do_reset();
    set_dis(16'h40, 7'd70, 7'd30, 6'h02, 1'b0); cyc();
    set_idle(); set_wb(4'd9, 1'b0); cyc();
    set_idle(); cyc();
    cyc();
    set_wb(4'd0, 1'b0); cyc();
    drain();

    // Reset while entries are pending and a commit is on the outputs.
    do_reset();
    for (int i = 0; i < 6; i++) begin rand_dis(); cyc(); end
    set_idle(); set_wb(4'd0, 1'b0); cyc();
    set_idle(); cyc();
    check("pre_rst_commit_valid", 32'(commit_valid), 1);
    rst = 1'b1; rand_dis(); set_wb(4'd1, 1'b0); cyc();
    rst = 1'b0;
    check_reset_outs();
    set_idle(); rand_dis(); cyc();
    set_idle();
    drain();

    // Randomized traffic including mispredicts and stray writebacks.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_idle();
      if ($urandom_range(2) != 0) rand_dis();
      if ($urandom_range(1) != 0) begin
        if (rob_q.size() > 0 && $urandom_range(7) != 0) begin
          k = int'($urandom_range(rob_q.size() - 1));
          set_wb(rob_q[k].tag, ($urandom_range(9) == 0));
        end else begin
          set_wb(4'($urandom), 1'b0);
        end
      end
      cyc();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
